// File: rtl/cnn_core_mac_seq.sv
// Sequenced MAC: one shared 12sx8u multiplier walks a runtime-length dot product
// from two ap_fifo streams and pushes one accumulated result per ap_start.
module cnn_core_mac_seq #(
    parameter int ACC_WIDTH = 24,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic [11:0]          w_dout,
    input  logic                 w_empty_n,
    output logic                 w_read,
    input  logic [7:0]           act_dout,
    input  logic                 act_empty_n,
    output logic                 act_read,
    output logic [ACC_WIDTH-1:0] res_din,
    input  logic                 res_full_n,
    output logic                 res_write
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_count;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic signed [19:0]    r_prod;
    logic                  r_prod_vld;

    logic                  w_pop;
    logic                  w_last;
    logic signed [20:0]    w_prod_full;
    logic [ACC_WIDTH-1:0]  w_prod_ext;

    // Activation is zero-extended so the signed multiply treats it as unsigned.
    assign w_prod_full = $signed(21'($signed(w_dout))) * $signed(21'({1'b0, act_dout}));
    assign w_prod_ext  = ACC_WIDTH'(r_prod);
    assign w_last      = (r_count == r_len - LEN_WIDTH'(1));

    assign w_read   = w_pop;
    assign act_read = w_pop;
    assign res_din  = r_acc;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        w_pop     = 1'b0;
        res_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_next = (cfg_len != '0) ? S_RUN : S_WRITE;
                end
            end
            S_RUN: begin
                // Both FIFOs pop together; a reset cycle must not consume data.
                w_pop = (r_count < r_len) && w_empty_n && act_empty_n && !ap_rst;
                if (w_pop && w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                res_write = res_full_n && !ap_rst;
                if (res_full_n) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_len      <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_len      <= cfg_len;
                        r_count    <= '0;
                        r_acc      <= '0;
                        r_prod_vld <= 1'b0;
                    end
                end
                S_RUN, S_DRAIN: begin
                    // Product register pipelines the multiply; acc absorbs it a cycle later.
                    if (r_prod_vld) begin
                        r_acc <= r_acc + w_prod_ext;
                    end
                    r_prod_vld <= w_pop;
                    if (w_pop) begin
                        r_prod  <= w_prod_full[19:0];
                        r_count <= r_count + LEN_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_core_mac_seq.sv
// Bench for cnn_core_mac_seq: FIFO models around the DUT, table vectors,
// hand-built stall/backpressure/reset sequences and randomized ops vs a sum model.
module tb_cnn_core_mac_seq;

    localparam int ACCW = 24;
    localparam int LENW = 8;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic            ap_start;
    logic            ap_done;
    logic            ap_idle;
    logic            ap_ready;
    logic [LENW-1:0] cfg_len;
    logic [11:0]     w_dout;
    logic            w_empty_n;
    logic            w_read;
    logic [7:0]      act_dout;
    logic            act_empty_n;
    logic            act_read;
    logic [ACCW-1:0] res_din;
    logic            res_full_n;
    logic            res_write;

    cnn_core_mac_seq #(.ACC_WIDTH(ACCW), .LEN_WIDTH(LENW)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .cfg_len     (cfg_len),
        .w_dout      (w_dout),
        .w_empty_n   (w_empty_n),
        .w_read      (w_read),
        .act_dout    (act_dout),
        .act_empty_n (act_empty_n),
        .act_read    (act_read),
        .res_din     (res_din),
        .res_full_n  (res_full_n),
        .res_write   (res_write)
    );

    always #5 ap_clk = ~ap_clk;

    // ---------------- FIFO models ----------------
    logic [11:0] w_mem [0:2047];
    logic [7:0]  a_mem [0:2047];
    int   w_wp = 0;
    int   w_rp = 0;
    int   a_rp = 0;
    int   cyc  = 0;
    logic flush_req = 1'b0;
    logic force_wst = 1'b0, force_ast = 1'b0, force_full = 1'b0;
    logic rand_en = 1'b0, rand_wst = 1'b0, rand_ast = 1'b0, rand_full = 1'b0;

    assign w_dout      = w_mem[w_rp[10:0]];
    assign act_dout    = a_mem[a_rp[10:0]];
    assign w_empty_n   = (w_wp != w_rp) && !force_wst && !rand_wst;
    assign act_empty_n = (w_wp != a_rp) && !force_ast && !rand_ast;
    assign res_full_n  = !force_full && !rand_full;

    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (flush_req) begin
            w_rp <= w_wp;
            a_rp <= w_wp;
        end else begin
            if (w_read)   w_rp <= w_rp + 1;
            if (act_read) a_rp <= a_rp + 1;
        end
    end

    always @(negedge ap_clk) begin
        rand_wst  = rand_en && ($urandom_range(0, 3) == 0);
        rand_ast  = rand_en && ($urandom_range(0, 3) == 0);
        rand_full = rand_en && ($urandom_range(0, 2) == 0);
    end

    // ---------------- event monitor ----------------
    int              rd_q[$];
    int              wr_cyc_q[$];
    logic [ACCW-1:0] wr_val_q[$];
    int              done_q[$];
    int              n_acc   = 0;
    int              n_proto = 0;

    always @(posedge ap_clk) begin
        if (ap_start && ap_idle && !ap_rst) n_acc++;
        if (w_read) rd_q.push_back(cyc);
        if (w_read !== act_read) n_proto++;
        if (w_read && !(w_empty_n && act_empty_n)) n_proto++;
        if (res_write) begin
            wr_cyc_q.push_back(cyc);
            wr_val_q.push_back(res_din);
        end
        if (ap_done) done_q.push_back(cyc);
        if (ap_done !== ap_ready) n_proto++;
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_mis = 0;
    int s, b_rd, b_wr, b_done, b_acc;

    function automatic longint wrap(input longint v);
        return v & 64'hFFFFFF;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic flush();
        flush_req = 1'b1;
        @(negedge ap_clk);
        flush_req = 1'b0;
    endtask

    task automatic push(input logic [11:0] w, input logic [7:0] a);
        w_mem[w_wp[10:0]] = w;
        a_mem[w_wp[10:0]] = a;
        w_wp++;
    endtask

    task automatic start_op(input int len);
        @(negedge ap_clk);
        b_rd   = rd_q.size();
        b_wr   = wr_cyc_q.size();
        b_done = done_q.size();
        b_acc  = n_acc;
        ap_start = 1'b1;
        cfg_len  = LENW'(len);
        s = cyc;
        @(negedge ap_clk);
        ap_start = 1'b0;
        cfg_len  = LENW'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (done_q.size() == b_done && k < bound) begin
            @(negedge ap_clk);
            k++;
        end
    endtask

    task automatic check_op(input string nm, input int len, input longint exp,
                            input int wr_off, input int done_off);
        int nrd, nwr, nd;
        nrd = rd_q.size() - b_rd;
        nwr = wr_cyc_q.size() - b_wr;
        nd  = done_q.size() - b_done;
        chk({nm, ".pops"}, nrd, len);
        chk({nm, ".writes"}, nwr, 1);
        chk({nm, ".dones"}, nd, 1);
        if (nwr >= 1) begin
            chk({nm, ".res"}, wr_val_q[b_wr], wrap(exp));
            if (wr_off >= 0) chk({nm, ".wr_lat"}, wr_cyc_q[b_wr] - s, wr_off);
        end
        if (nd >= 1 && done_off >= 0) chk({nm, ".done_lat"}, done_q[b_done] - s, done_off);
        chk({nm, ".proto"}, n_proto, 0);
        chk({nm, ".idle"}, ap_idle, 1);
        chk({nm, ".starts"}, n_acc - b_acc, 1);
    endtask

    typedef struct {
        int     len;
        int     w0;
        int     wstep;
        int     act;
        longint exp_res;
        int     wr_off;
        int     done_off;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        longint sum;
        logic [11:0] wv;
        logic [7:0]  av;
        int len;

        tbl[0] = '{9,     1, 1,  10,      450, 11, 12};
        tbl[1] = '{9, -2048, 0, 255, -4700160, 11, 12};
        tbl[2] = '{20, -2048, 0, 255,  6332416, 22, 23};
        tbl[3] = '{1,    -7, 0, 200,    -1400,  3,  4};
        tbl[4] = '{0,     0, 0,   0,        0,  1,  2};
        tbl[5] = '{16, 2047, 0, 255,  8351760, 18, 19};

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        cfg_len  = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst.idle", ap_idle, 1);
        chk("rst.done", ap_done, 0);
        chk("rst.ready", ap_ready, 0);
        chk("rst.w_read", w_read, 0);
        chk("rst.act_read", act_read, 0);
        chk("rst.res_write", res_write, 0);
        chk("rst.res_din", res_din, 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // Table vectors, FIFOs always ready
        for (int t = 0; t < 6; t++) begin
            flush();
            for (int i = 0; i < tbl[t].len; i++) begin
                wv = 12'(tbl[t].w0 + i * tbl[t].wstep);
                push(wv, 8'(tbl[t].act));
            end
            start_op(tbl[t].len);
            wait_done(100);
            check_op($sformatf("vec%0d", t), tbl[t].len, tbl[t].exp_res,
                     tbl[t].wr_off, tbl[t].done_off);
            if (tbl[t].len > 0 && rd_q.size() - b_rd == tbl[t].len) begin
                chk($sformatf("vec%0d.first_rd", t), rd_q[b_rd] - s, 1);
                chk($sformatf("vec%0d.last_rd", t), rd_q[$] - s, tbl[t].len);
            end
        end

        // Input stall: activation FIFO empty for 3 cycles after the 2nd pop
        flush();
        push(12'd3, 8'd7);
        push(-12'sd4, 8'd8);
        push(12'd5, 8'd9);
        push(12'd6, 8'd10);
        start_op(4);
        k = 0;
        while (rd_q.size() - b_rd < 2 && k < 20) begin
            @(negedge ap_clk);
            k++;
        end
        force_ast = 1'b1;
        repeat (3) @(negedge ap_clk);
        force_ast = 1'b0;
        wait_done(100);
        check_op("stall", 4, 94, 9, 10);

        // Output backpressure with a stray ap_start mid-run
        flush();
        push(12'd100, 8'd2);
        push(-12'sd50, 8'd3);
        push(12'd7, 8'd4);
        force_full = 1'b1;
        start_op(3);
        @(negedge ap_clk);
        ap_start = 1'b1;
        cfg_len  = 8'd5;
        @(negedge ap_clk);
        ap_start = 1'b0;
        @(negedge ap_clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk("bp.res_din_hold", res_din, 78);
            chk("bp.no_write", res_write, 0);
        end
        @(negedge ap_clk);
        force_full = 1'b0;
        wait_done(100);
        check_op("bp", 3, 78, 10, 11);

        // Reset in RUN after 3 of 9 pops, then a 2-tap op on the leftovers
        flush();
        for (int i = 0; i < 9; i++) push(12'(10 * (i + 1)), 8'(i + 1));
        start_op(9);
        k = 0;
        while (rd_q.size() - b_rd < 3 && k < 20) begin
            @(negedge ap_clk);
            k++;
        end
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("rstrun.idle", ap_idle, 1);
        repeat (4) @(negedge ap_clk);
        chk("rstrun.pops", rd_q.size() - b_rd, 3);
        chk("rstrun.writes", wr_cyc_q.size() - b_wr, 0);
        chk("rstrun.dones", done_q.size() - b_done, 0);
        start_op(2);
        wait_done(100);
        check_op("rstrun2", 2, 410, 4, 5);

        // Randomized ops with random stalls and backpressure
        rand_en = 1'b1;
        for (int it = 0; it < 30; it++) begin
            flush();
            len = $urandom_range(0, 24);
            sum = 0;
            for (int i = 0; i < len; i++) begin
                wv = 12'($urandom);
                av = 8'($urandom);
                push(wv, av);
                sum += longint'($signed(wv)) * longint'(av);
            end
            start_op(len);
            wait_done(600);
            check_op($sformatf("rnd%0d", it), len, sum, -1, -1);
        end
        rand_en = 1'b0;
        @(negedge ap_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
